// File: rtl/lifegame_arith_pkg.sv
// Shared arithmetic definitions for the LifeGame datapath blocks (divider and multiplier).
// Contents:
//   ST_IDLE/ST_RUN/ST_DONE  - state encodings shared by the sequential arithmetic units
//   N_WIDTH_DEF/D_WIDTH_DEF - default operand widths, shared with the divider
//   mul_state_e             - typed FSM state built on the shared encodings
//   clog2/cnt_width         - helpers for sizing iteration counters
package lifegame_arith_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int unsigned N_WIDTH_DEF = 8;
   localparam int unsigned D_WIDTH_DEF = 2;

   typedef enum logic [1:0] {
      StIdle = ST_IDLE,
      StRun  = ST_RUN,
      StDone = ST_DONE
   } mul_state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      while ((32'd1 << res) < value) begin
         res = res + 1;
      end
      return res;
   endfunction

   // A counter needs at least one bit even when only one iteration is run.
   function automatic int unsigned cnt_width(input int unsigned iterations);
      return (clog2(iterations) < 1) ? 1 : clog2(iterations);
   endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add multiplier iteration (purely combinational).
// Ports:
//   acc_i/acc_o       - running accumulator in / next
//   mcand_i/mcand_o   - multiplicand, shifted left by one each step
//   mplier_i/mplier_o - multiplier, shifted right by one each step; bit 0 selects the add
module mul_step #(
   parameter int unsigned P_WIDTH = 10,
   parameter int unsigned D_WIDTH = 2
) (
   input  logic [P_WIDTH-1:0] acc_i,
   input  logic [P_WIDTH-1:0] mcand_i,
   input  logic [D_WIDTH-1:0] mplier_i,
   output logic [P_WIDTH-1:0] acc_o,
   output logic [P_WIDTH-1:0] mcand_o,
   output logic [D_WIDTH-1:0] mplier_o
);

   always_comb begin
      acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
      mcand_o  = mcand_i << 1;
      mplier_o = mplier_i >> 1;
   end

endmodule

// File: rtl/mul_restore.sv
// Sequential shift-add multiplier: product = quotient * denominator + remain.
// Rebuilds a numerator from a divider result, one multiplier bit per cycle, constant latency.
// Ports:
//   clk, rst_n    - clock (rising edge), asynchronous active-low reset
//   start         - request strobe, sampled only when idle
//   quotient      - multiplicand (N_WIDTH)
//   denominator   - multiplier (D_WIDTH)
//   remain        - addend (D_WIDTH)
//   busy          - high while computing or holding a result
//   result_valid  - product is valid; held until result_ready
//   result_ready  - consumer accepts the product
//   product       - quotient*denominator + remain (N_WIDTH+D_WIDTH)
//   rem_err       - only with MUL_RESTORE_REM_CHECK_EN defined: the operands are not a legal
//                   divider output (denominator==0 or remain>=denominator); valid with result_valid
module mul_restore
   import lifegame_arith_pkg::*;
#(
   parameter int unsigned N_WIDTH = N_WIDTH_DEF,
   parameter int unsigned D_WIDTH = D_WIDTH_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [N_WIDTH-1:0]           quotient,
   input  logic [D_WIDTH-1:0]           denominator,
   input  logic [D_WIDTH-1:0]           remain,
   output logic                         busy,
   output logic                         result_valid,
   input  logic                         result_ready,
   output logic [N_WIDTH+D_WIDTH-1:0]   product
`ifdef MUL_RESTORE_REM_CHECK_EN
   ,
   output logic                         rem_err
`endif
);

   localparam int unsigned P_WIDTH = N_WIDTH + D_WIDTH;
   localparam int unsigned CNT_W   = cnt_width(D_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D_WIDTH - 1);

   mul_state_e           state_q,   state_d;
   logic [P_WIDTH-1:0]   acc_q,     acc_d;
   logic [P_WIDTH-1:0]   mcand_q,   mcand_d;
   logic [D_WIDTH-1:0]   mplier_q,  mplier_d;
   logic [CNT_W-1:0]     cnt_q,     cnt_d;
   logic [P_WIDTH-1:0]   product_q, product_d;

   logic [P_WIDTH-1:0]   step_acc;
   logic [P_WIDTH-1:0]   step_mcand;
   logic [D_WIDTH-1:0]   step_mplier;

   mul_step #(
      .P_WIDTH (P_WIDTH),
      .D_WIDTH (D_WIDTH)
   ) u_mul_step (
      .acc_i    (acc_q),
      .mcand_i  (mcand_q),
      .mplier_i (mplier_q),
      .acc_o    (step_acc),
      .mcand_o  (step_mcand),
      .mplier_o (step_mplier)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               mcand_d  = P_WIDTH'(quotient);
               mplier_d = denominator;
               acc_d    = P_WIDTH'(remain);
               cnt_d    = '0;
               state_d  = StRun;
            end
         end
         StRun: begin
            acc_d    = step_acc;
            mcand_d  = step_mcand;
            mplier_d = step_mplier;
            cnt_d    = cnt_q + CNT_W'(1);
            // Always exactly D_WIDTH iterations, even once mplier is exhausted.
            if (cnt_q == CNT_LAST) begin
               state_d   = StDone;
               product_d = step_acc;
            end
         end
         StDone: begin
            if (result_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      busy         = (state_q != StIdle);
      result_valid = (state_q == StDone);
      product      = product_q;
   end

`ifdef MUL_RESTORE_REM_CHECK_EN
   logic rem_err_q, rem_err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_err_q <= 1'b0;
      end else begin
         rem_err_q <= rem_err_d;
      end
   end

   always_comb begin
      rem_err_d = rem_err_q;
      if ((state_q == StIdle) && start) begin
         rem_err_d = (denominator == '0) || (remain >= denominator);
      end else if ((state_q == StDone) && result_ready) begin
         rem_err_d = 1'b0;
      end
   end

   // Flag is captured at start but only presented alongside the result.
   always_comb begin
      rem_err = rem_err_q && (state_q == StDone);
   end
`endif

endmodule
